// File: rtl/count_mon_pkg.sv
// Shared encodings for the count sequence monitor: FSM states and per-sample classification codes.
package count_mon_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    CL_LEGAL   = 3'd0,
    CL_WRAP    = 3'd1,
    CL_RESTART = 3'd2,
    CL_HOLD    = 3'd3,
    CL_ERR     = 3'd4
  } class_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks a free-running counter for +1 sequencing, counting wraps and errors.
// Build option COUNT_MON_HOLD_EN: a repeated value is a legal hold and drives stall.
//   state | meaning
//   SYNC  | waiting for first sample to seed prev
//   TRACK | comparing samples, no error seen
//   FAULT | at least one error seen; tracking continues until clear/reset
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W       = 2,
  parameter int WRAP_CNT_W  = 8,
  parameter int ERR_CNT_W   = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      count_in,
  input  logic                  sample_en,
  input  logic                  clear,
  output logic [1:0]            state,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  seq_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]      bad_value,
  output logic                  stall
);

`ifdef COUNT_MON_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  class_t           cls;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] exp_val;
  logic             sample_chk;
  logic             is_err;
  logic             wrap_inc;
  logic             err_inc;

  assign exp_val    = prev_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign sample_chk = sample_en && (state_q != ST_SYNC);

  // When prev is max, exp_val is 0, so a 0 after max is always caught as a wrap first.
  always_comb begin
    cls = CL_ERR;
    if (count_in == exp_val) begin
      cls = (prev_q == {CNT_W{1'b1}}) ? CL_WRAP : CL_LEGAL;
    end else if (count_in == '0) begin
      cls = CL_RESTART;
    end else if (count_in == prev_q) begin
      cls = CL_HOLD;
    end
  end

  assign is_err   = (cls == CL_ERR) || ((cls == CL_HOLD) && !HOLD_EN);
  assign wrap_inc = sample_chk && (cls == CL_WRAP);
  assign err_inc  = sample_chk && is_err;

  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      case (state_q)
        ST_SYNC:  state_d = ST_TRACK;
        ST_TRACK: state_d = is_err ? ST_FAULT : ST_TRACK;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= ST_SYNC;
      prev_q     <= '0;
      wrap_pulse <= 1'b0;
      seq_err    <= 1'b0;
      bad_value  <= '0;
    end else begin
      state_q    <= state_d;
      wrap_pulse <= wrap_inc;
      if (sample_en) begin
        prev_q <= count_in;
      end
      if (err_inc) begin
        seq_err <= 1'b1;
        if (!seq_err) begin
          bad_value <= count_in;
        end
      end
    end
  end

  assign state = state_q;

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (wrap_inc),
    .cnt   (wrap_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (err_inc),
    .cnt   (err_cnt)
  );

`ifdef COUNT_MON_HOLD_EN
  localparam int HOLD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(STALL_LIMIT);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              stall_q;

  // Hold run length saturates at the limit; only the threshold matters downstream.
  always_comb begin
    hold_d = hold_q;
    if (sample_chk) begin
      if (cls == CL_HOLD) begin
        if (hold_q < HOLD_LIMIT) begin
          hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end else begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      stall_q <= (hold_d >= HOLD_LIMIT);
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor with a behavioural reference model and per-cycle compare.
module tb_count_seq_monitor;

  logic       clk;
  logic       reset;
  logic [1:0] count_in;
  logic       sample_en;
  logic       clear;
  logic [1:0] state;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       seq_err;
  logic [7:0] err_cnt;
  logic [1:0] bad_value;
  logic       stall;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 0;

  // reference model (values the outputs must show after the next clock edge)
  int m_state, m_wrap_pulse, m_wrap_cnt, m_seq_err, m_err_cnt, m_bad, m_stall;
  int m_prev, m_holdrun;

  count_seq_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .sample_en  (sample_en),
    .clear      (clear),
    .state      (state),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt),
    .bad_value  (bad_value),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit clr, input bit en, input int c);
    bit err;
    m_wrap_pulse = 0;
    if (rst || clr) begin
      m_state = 0; m_wrap_cnt = 0; m_seq_err = 0; m_err_cnt = 0;
      m_bad = 0; m_stall = 0; m_prev = 0; m_holdrun = 0;
    end else if (en) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        err = 0;
        if (c == (m_prev + 1) % 4) begin
          if (m_prev == 3) begin
            m_wrap_pulse = 1;
            if (m_wrap_cnt < 255) m_wrap_cnt++;
          end
          m_holdrun = 0;
        end else if (c == 0) begin
          m_holdrun = 0;
        end else if (c == m_prev) begin
`ifdef COUNT_MON_HOLD_EN
          m_holdrun++;
`else
          err = 1;
`endif
        end else begin
          err = 1;
          m_holdrun = 0;
        end
        if (err) begin
          if (m_err_cnt < 255) m_err_cnt++;
          if (m_seq_err == 0) m_bad = c;
          m_seq_err = 1;
          m_state = 2;
        end
`ifdef COUNT_MON_HOLD_EN
        m_stall = (m_holdrun >= 4) ? 1 : 0;
`endif
      end
      m_prev = c;
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit en, input int c);
    reset     = rst;
    clear     = clr;
    sample_en = en;
    count_in  = 2'(c);
    model(rst, clr, en, c);
    @(posedge clk);
    #2;
  endtask

  task automatic smp(input int c);
    step(0, 0, 1, c);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("state",      int'(state),      m_state);
      check("wrap_pulse", int'(wrap_pulse), m_wrap_pulse);
      check("wrap_cnt",   int'(wrap_cnt),   m_wrap_cnt);
      check("seq_err",    int'(seq_err),    m_seq_err);
      check("err_cnt",    int'(err_cnt),    m_err_cnt);
      check("bad_value",  int'(bad_value),  m_bad);
      check("stall",      int'(stall),      m_stall);
    end
  end

  initial begin
    reset = 1; clear = 0; sample_en = 0; count_in = 0;
    chk_en = 1;
    step(1, 0, 0, 0);
    check("rst_state", int'(state), 0);
    check("rst_wrap_cnt", int'(wrap_cnt), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // basic counting with one wrap
    smp(0);
    check("sync_to_track", int'(state), 1);
    smp(1); smp(2); smp(3); smp(0);
    check("wrap_pulse_hi", int'(wrap_pulse), 1);
    smp(1);
    check("wrap_pulse_lo", int'(wrap_pulse), 0);
    check("wrap_cnt_1", int'(wrap_cnt), 1);
    check("no_err", int'(seq_err), 0);

    // error capture: 0,1,3 then 0,2
    smp(0); smp(1); smp(3);
    check("err_flag", int'(seq_err), 1);
    check("err_cnt_1", int'(err_cnt), 1);
    check("bad_3", int'(bad_value), 3);
    check("fault", int'(state), 2);
    smp(0); smp(2);
    check("err_cnt_2", int'(err_cnt), 2);
    check("bad_kept", int'(bad_value), 3);

    // clear wins over an erroneous sample
    step(0, 1, 1, 1);
    check("clr_state", int'(state), 0);
    check("clr_err_cnt", int'(err_cnt), 0);
    check("clr_wrap_cnt", int'(wrap_cnt), 0);
    check("clr_seq_err", int'(seq_err), 0);

    // restart is legal
    smp(1); smp(2); smp(0);
    check("restart_no_err", int'(err_cnt), 0);
    check("restart_no_wrap", int'(wrap_cnt), 0);
    check("restart_state", int'(state), 1);

    // disabled samples hold everything
    step(0, 0, 0, 3);
    step(0, 0, 0, 2);
    smp(1);
    check("gap_no_err", int'(err_cnt), 0);

    // wrap saturation
    for (int i = 0; i < 300; i++) begin
      smp(2); smp(3); smp(0); smp(1);
    end
    check("wrap_sat", int'(wrap_cnt), 255);

    // error saturation: each 0->2 jump is an error, 2->0 is a restart
    step(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      smp(0); smp(2);
    end
    check("err_sat", int'(err_cnt), 255);
    check("err_sat_bad", int'(bad_value), 2);

    // hold sequence
    step(0, 1, 0, 0);
    smp(2); smp(2); smp(2); smp(2);
`ifdef COUNT_MON_HOLD_EN
    check("stall_pre", int'(stall), 0);
`endif
    smp(2);
`ifdef COUNT_MON_HOLD_EN
    check("hold_err_cnt", int'(err_cnt), 0);
    check("stall_hi", int'(stall), 1);
`else
    check("hold_err_cnt", int'(err_cnt), 4);
    check("stall_tied", int'(stall), 0);
`endif
    smp(3);
    check("stall_lo", int'(stall), 0);

    // reset mid-run
    smp(1);
    step(1, 0, 1, 2);
    check("rst2_state", int'(state), 0);
    check("rst2_err", int'(seq_err), 0);
    smp(3);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
